// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receiver (and the planned
// transmitter).
//   uart_state_t : receiver frame states
//   PAR_*        : parity mode encodings for the PARITY parameter
//   cnt_w()      : width of the per-bit clock counter
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Counter runs 0..clks_per_bit-1 inside each bit window.
  function automatic int cnt_w(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg_if
// Output bus of the UART receiver towards the word consumer.
//   data_out    : received word, stable while data_valid=1
//   data_valid  : word and status available
//   data_ready  : consumer accepts (handshake on data_valid & data_ready)
//   parity_err  : parity mismatch for the held word
//   frame_err   : a stop bit of the held word sampled 0
//   break_det   : held word is a break (all-zero frame with frame error)
//   overrun     : sticky, a completed frame was dropped
//   busy        : receiver is inside a frame
// master modport = receiver side, slave modport = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data_out, data_valid, parity_err, frame_err, break_det, overrun, busy,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_err, frame_err, break_det, overrun, busy,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Two-flop synchronizer for the asynchronous serial line plus the
// three-sample majority vote used to decide each bit.
//   clk, reset   : system clock, synchronous active-high reset
//   i_rx_in      : raw asynchronous serial line (idle high)
//   i_smp_lo     : capture strobe for the first sample (cnt = H-1)
//   i_smp_mid    : capture strobe for the second sample (cnt = H)
//   o_rxs        : synchronized line
//   o_maj        : majority of the two captured samples and the current
//                  o_rxs, valid in the decision cycle (cnt = H+1)
// ---------------------------------------------------------------------------
module uart_rx_sampler (
  input  logic clk,
  input  logic reset,
  input  logic i_rx_in,
  input  logic i_smp_lo,
  input  logic i_smp_mid,
  output logic o_rxs,
  output logic o_maj
);

  logic r_sync1;
  logic r_sync2;
  logic r_smp_lo;
  logic r_smp_mid;

  // Everything presets to 1 so the idle line state is seen right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_smp_lo  <= 1'b1;
      r_smp_mid <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_sync2 <= r_sync1;
      if (i_smp_lo) begin
        r_smp_lo <= r_sync2;
      end
      if (i_smp_mid) begin
        r_smp_mid <= r_sync2;
      end
    end
  end

  assign o_rxs = r_sync2;

  // Third sample is the live synchronized line, so the vote is ready in the
  // decision cycle itself without an extra register stage.
  assign o_maj = (r_smp_lo & r_smp_mid) | (r_smp_lo & r_sync2) | (r_smp_mid & r_sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver: DATA_BITS data bits (LSB first), optional odd
// or even parity, 1 or 2 stop bits, mid-bit 3-sample majority, error/break
// flags and a valid/ready output register with overrun detection.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   rx_in   : asynchronous serial line, idle high
//   rx_bus  : output bus (data, valid/ready, status flags, busy)
// Parameters: CLKS_PER_BIT (>= 8), DATA_BITS (5..9), PARITY (0/1/2),
// STOP_BITS (1/2).
// ---------------------------------------------------------------------------
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_in,
  uart_rx_cfg_if.master rx_bus
);

  localparam int CNT_W = cnt_w(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SMP_LO   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] SMP_MID  = CNT_W'(H);
  localparam logic [CNT_W-1:0] SMP_DEC  = CNT_W'(H + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit               PAR_EN    = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  localparam bit               PAR_IS_ODD = (PARITY == PAR_ODD);

  // FSM
  uart_state_t r_state;
  uart_state_t w_state_next;

  // Frame datapath
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_err;
  logic                 r_arm;

  // Output register
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_brk;
  logic                 r_ovr;

  // FSM outputs and helpers
  logic w_rxs;
  logic w_maj;
  logic w_smp_lo;
  logic w_smp_mid;
  logic w_decide;
  logic w_win_end;
  logic w_start_det;
  logic w_complete;
  logic w_busy;
  logic w_perr_now;
  logic w_ferr_now;
  logic w_brk_now;
  logic w_load;
  logic w_hs;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .i_rx_in   (rx_in),
    .i_smp_lo  (w_smp_lo),
    .i_smp_mid (w_smp_mid),
    .o_rxs     (w_rxs),
    .o_maj     (w_maj)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_det) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        // A start bit that votes high was a glitch: abandon silently.
        if (w_decide && w_maj) begin
          w_state_next = S_IDLE;
        end else if (w_win_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_win_end && (r_bit_idx == IDX_LAST)) begin
          w_state_next = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_win_end) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at the decision point so a back-to-back start edge is caught.
        if (w_complete) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_smp_lo    = w_busy && (r_cnt == SMP_LO);
    w_smp_mid   = w_busy && (r_cnt == SMP_MID);
    w_decide    = w_busy && (r_cnt == SMP_DEC);
    w_win_end   = (r_cnt == CNT_LAST);
    w_start_det = (r_state == S_IDLE) && r_arm && !w_rxs;
    w_complete  = (r_state == S_STOP) && w_decide && (r_stop_idx == STOP_LAST);
  end

  // Frame status evaluated in the completion cycle; the last stop bit's vote
  // is still combinational here, hence folded in directly.
  assign w_ferr_now = r_stop_err | ~w_maj;
  assign w_perr_now = PAR_EN && ((^r_shift ^ r_par_bit) != PAR_IS_ODD);
  assign w_brk_now  = (r_shift == '0) && (!PAR_EN || !r_par_bit) && w_ferr_now;

  // ---------------- Frame datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
      r_arm      <= 1'b0;
    end else begin
      // The detecting IDLE cycle is count 0 of the start window.
      if (w_state_next == S_IDLE) begin
        r_cnt <= '0;
      end else if (w_win_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_start_det) begin
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
        r_stop_err <= 1'b0;
      end

      if ((r_state == S_DATA) && w_decide) begin
        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      end
      if ((r_state == S_DATA) && w_win_end) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if ((r_state == S_PARITY) && w_decide) begin
        r_par_bit <= w_maj;
      end

      if ((r_state == S_STOP) && w_decide && !w_maj) begin
        r_stop_err <= 1'b1;
      end
      if ((r_state == S_STOP) && w_win_end) begin
        r_stop_idx <= r_stop_idx + 1'b1;
      end

      // After a break the line is still low; stay disarmed until it is high
      // again so a stuck-low line yields exactly one break frame.
      if (w_complete && w_brk_now) begin
        r_arm <= 1'b0;
      end else if (w_rxs) begin
        r_arm <= 1'b1;
      end
    end
  end

  // ---------------- Output register ----------------
  assign w_hs   = r_valid && rx_bus.data_ready;
  assign w_load = w_complete && (!r_valid || rx_bus.data_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_perr  <= w_perr_now;
        r_ferr  <= w_ferr_now;
        r_brk   <= w_brk_now;
        r_valid <= 1'b1;
        r_ovr   <= 1'b0;
      end else if (w_complete) begin
        // Consumer still holds the previous word: drop this frame.
        r_ovr <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign rx_bus.data_out   = r_data;
  assign rx_bus.data_valid = r_valid;
  assign rx_bus.parity_err = r_perr;
  assign rx_bus.frame_err  = r_ferr;
  assign rx_bus.break_det  = r_brk;
  assign rx_bus.overrun    = r_ovr;
  assign rx_bus.busy       = w_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;

  always #5 clk = ~clk;

  // bus0: 8N1 receiver, bus1: 8 data, even parity, 2 stop bits
  uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .rx_in(rx0), .rx_bus(bus0)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .rx_in(rx1), .rx_bus(bus1)
  );

  typedef struct {
    int d;
    int pe;
    int fe;
    int bk;
  } rec_t;

  typedef struct {
    int sel;
    int data;
    int pbit;
    int s0;
    int s1;
    int exp_d;
    int exp_pe;
    int exp_fe;
    int exp_bk;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;
  rec_t q0[$];
  rec_t q1[$];
  int vcyc0 = 0;
  int vcyc1 = 0;

  // Capture every accepted word; count cycles with valid high.
  always @(negedge clk) begin
    rec_t r;
    if (!reset) begin
      if (bus0.data_valid) vcyc0++;
      if (bus1.data_valid) vcyc1++;
      if (bus0.data_valid && bus0.data_ready) begin
        r.d = int'(bus0.data_out); r.pe = int'(bus0.parity_err);
        r.fe = int'(bus0.frame_err); r.bk = int'(bus0.break_det);
        q0.push_back(r);
      end
      if (bus1.data_valid && bus1.data_ready) begin
        r.d = int'(bus1.data_out); r.pe = int'(bus1.parity_err);
        r.fe = int'(bus1.frame_err); r.bk = int'(bus1.break_det);
        q1.push_back(r);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit b, input int n);
    if (sel != 0) rx1 = b; else rx0 = b;
    repeat (n) @(negedge clk);
  endtask

  // Full frame: start, 8 data LSB first, parity (bus1 only), stop(s), idle.
  task automatic send(input int sel, input int data, input int pbit, input int s0, input int s1);
    drive(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(sel, bit'((data >> i) & 1), CPB);
    if (sel != 0) drive(sel, bit'(pbit & 1), CPB);
    drive(sel, bit'(s0 & 1), CPB);
    if (sel != 0) drive(sel, bit'(s1 & 1), CPB);
    drive(sel, 1'b1, 3 * CPB);
  endtask

  // Reference: frame contents derived from the line-level rules.
  function automatic rec_t model(input int sel, input int data, input int pbit, input int s0, input int s1);
    rec_t r;
    r.d  = data & 255;
    r.pe = (sel != 0) ? int'((($countones(r.d) + (pbit & 1)) % 2) != 0) : 0;
    r.fe = (sel != 0) ? int'(s0 == 0 || s1 == 0) : int'(s0 == 0);
    r.bk = int'(r.d == 0 && (sel == 0 || pbit == 0) && r.fe != 0);
    return r;
  endfunction

  task automatic expect_word(input int sel, input string name, input rec_t e);
    rec_t r;
    int sz;
    sz = (sel != 0) ? q1.size() : q0.size();
    chk({name, " words"}, sz, 1);
    if (sz > 0) begin
      r = (sel != 0) ? q1.pop_front() : q0.pop_front();
      chk({name, " data"}, r.d, e.d);
      chk({name, " parity_err"}, r.pe, e.pe);
      chk({name, " frame_err"}, r.fe, e.fe);
      chk({name, " break_det"}, r.bk, e.bk);
    end
    if (sel != 0) q1.delete(); else q0.delete();
  endtask

  vec_t vecs[8];

  initial begin
    rec_t e;
    int v_before;
    int saw;
    int back;

    vecs[0] = '{0, 8'hAF, 0, 1, 1, 8'hAF, 0, 0, 0};
    vecs[1] = '{1, 8'h5A, 1, 1, 1, 8'h5A, 1, 0, 0};
    vecs[2] = '{1, 8'h5A, 0, 1, 1, 8'h5A, 0, 0, 0};
    vecs[3] = '{0, 8'h33, 0, 0, 1, 8'h33, 0, 1, 0};
    vecs[4] = '{1, 8'h00, 0, 1, 0, 8'h00, 0, 1, 1};
    vecs[5] = '{1, 8'h81, 0, 0, 1, 8'h81, 0, 1, 0};
    vecs[6] = '{0, 8'h00, 0, 1, 1, 8'h00, 0, 0, 0};
    vecs[7] = '{1, 8'h07, 1, 1, 1, 8'h07, 0, 0, 0};

    bus0.data_ready = 1'b1;
    bus1.data_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset valid0", int'(bus0.data_valid), 0);
    chk("reset busy0", int'(bus0.busy), 0);
    chk("reset overrun0", int'(bus0.overrun), 0);
    chk("reset data0", int'(bus0.data_out), 0);
    chk("reset valid1", int'(bus1.data_valid), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      v_before = (vecs[i].sel != 0) ? vcyc1 : vcyc0;
      send(vecs[i].sel, vecs[i].data, vecs[i].pbit, vecs[i].s0, vecs[i].s1);
      e.d = vecs[i].exp_d; e.pe = vecs[i].exp_pe; e.fe = vecs[i].exp_fe; e.bk = vecs[i].exp_bk;
      expect_word(vecs[i].sel, $sformatf("vec%0d", i), e);
      chk($sformatf("vec%0d valid cycles", i), ((vecs[i].sel != 0) ? vcyc1 : vcyc0) - v_before, 1);
      chk($sformatf("vec%0d busy idle", i), int'((vecs[i].sel != 0) ? bus1.busy : bus0.busy), 0);
      $display("[TB] vec%0d sel=%0d data=%02h done", i, vecs[i].sel, vecs[i].data);
    end

    // Break with the line stuck low: one break word, then nothing.
    v_before = vcyc0;
    drive(0, 1'b0, 20 * CPB);
    chk("break busy while low", int'(bus0.busy), 0);
    chk("break valid cycles", vcyc0 - v_before, 1);
    e.d = 0; e.pe = 0; e.fe = 1; e.bk = 1;
    expect_word(0, "break", e);
    drive(0, 1'b1, 3 * CPB);
    send(0, 8'h01, 0, 1, 1);
    e.d = 8'h01; e.pe = 0; e.fe = 0; e.bk = 0;
    expect_word(0, "after break", e);
    $display("[TB] break sequence done");

    // Glitch: 3 clocks low then high
    v_before = vcyc0;
    drive(0, 1'b0, 3);
    rx0 = 1'b1;
    saw = 0; back = 0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (bus0.busy) saw = 1;
      else if (saw != 0 && back == 0) back = i;
    end
    chk("glitch busy returns", int'(saw != 0 && back > 0 && back < CPB), 1);
    chk("glitch no word", vcyc0 - v_before, 0);
    $display("[TB] glitch saw_busy=%0d back_after=%0d", saw, back);

    // Overrun
    bus0.data_ready = 1'b0;
    send(0, 8'h11, 0, 1, 1);
    send(0, 8'h22, 0, 1, 1);
    chk("overrun held data", int'(bus0.data_out), 8'h11);
    chk("overrun valid", int'(bus0.data_valid), 1);
    chk("overrun flag", int'(bus0.overrun), 1);
    @(posedge clk);
    #2 bus0.data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("overrun cleared", int'(bus0.overrun), 0);
    chk("overrun valid dropped", int'(bus0.data_valid), 0);
    e.d = 8'h11; e.pe = 0; e.fe = 0; e.bk = 0;
    expect_word(0, "overrun accepted", e);
    $display("[TB] overrun sequence done");

    // Reset mid-DATA of 0xC3
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(0, bit'((8'hC3 >> i) & 1), CPB);
    chk("midframe busy", int'(bus0.busy), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    rx0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset valid", int'(bus0.data_valid), 0);
    chk("midreset busy", int'(bus0.busy), 0);
    chk("midreset data", int'(bus0.data_out), 0);
    chk("midreset flags", int'({bus0.parity_err, bus0.frame_err, bus0.break_det, bus0.overrun}), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    v_before = vcyc0;
    drive(0, 1'b1, 4 * CPB);
    chk("midreset no word", vcyc0 - v_before, 0);
    send(0, 8'h3C, 0, 1, 1);
    e.d = 8'h3C; e.pe = 0; e.fe = 0; e.bk = 0;
    expect_word(0, "after reset", e);
    $display("[TB] reset sequence done");

    // Randomized frames against the reference model
    for (int i = 0; i < 40; i++) begin
      int sel, data, pbit, s0, s1;
      sel  = int'($urandom_range(1, 0));
      data = (i % 7 == 3) ? 0 : int'($urandom_range(255, 0));
      pbit = int'($urandom_range(1, 0));
      s0   = ($urandom_range(3, 0) == 0) ? 0 : 1;
      s1   = ($urandom_range(3, 0) == 0) ? 0 : 1;
      send(sel, data, pbit, s0, s1);
      e = model(sel, data, pbit, s0, s1);
      expect_word(sel, $sformatf("rnd%0d", i), e);
      $display("[TB] rnd%0d sel=%0d data=%02h p=%0d stop=%0d%0d", i, sel, data, pbit, s0, s1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
